// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - shared edge-select codes and elaboration helpers for multi_edge_detect
package edge_detect_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;

  // Number of bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - one channel: synchroniser, persistence filter, edge detect, saturating counter
module edge_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             clr,
  output logic             out,
  output logic             level,
  output logic [CNT_W-1:0] count
);

  // The filter counter needs clog2(FILT_LEN+1) bits; keep at least one bit so
  // the bypass case (FILT_LEN=0) still elaborates a legal vector.
  localparam int FW_RAW = clog2(FILT_LEN + 1);
  localparam int FW     = (FW_RAW < 1) ? 1 : FW_RAW;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [FW-1:0]          fcnt;
  logic                   accept;
  logic                   rise;
  logic                   fall;
  logic                   qualify;
  logic                   fire;
  logic                   sat;

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != level) && (fcnt == FILT_MAX);
  assign rise   = accept & s;
  assign fall   = accept & ~s;
  assign fire   = qualify & en;
  assign sat    = &count;

  // Resynchronise the asynchronous input through a plain shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  // Persistence filter: a mismatch must survive FILT_LEN+1 cycles before level follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      level <= 1'b0;
    end else if (s == level) begin
      fcnt <= '0;
    end else if (accept) begin
      fcnt  <= '0;
      level <= s;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // Edge qualification against the run-time mode, evaluated on the accepting edge.
  always_comb begin
    qualify = 1'b0;
    case (mode)
      EDGE_RISE: qualify = rise;
      EDGE_FALL: qualify = fall;
      EDGE_BOTH: qualify = rise | fall;
      EDGE_NONE: qualify = 1'b0;
      default:   qualify = 1'b0;
    endcase
  end

  // Registered one-cycle pulse; clr deliberately has no effect here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 1'b0;
    end else begin
      out <= fire;
    end
  end

  // Saturating edge counter; clr takes priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (fire && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multi_edge_detect.sv
// rtl/multi_edge_detect.sv - N-channel filtered edge detector with per-channel saturating counters
module multi_edge_detect
  import edge_detect_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 0,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in,
  input  logic [1:0]            mode,
  input  logic                  en,
  input  logic                  clr,
  output logic [N_CH-1:0]       out,
  output logic [N_CH-1:0]       level,
  output logic                  any_edge,
  output logic [N_CH*CNT_W-1:0] count
);

  // Channels share only clock, reset and the global controls.
  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (in[k]),
      .mode (mode),
      .en   (en),
      .clr  (clr),
      .out  (out[k]),
      .level(level[k]),
      .count(count[k*CNT_W +: CNT_W])
    );
  end

  assign any_edge = |out;

endmodule

// File: tb/tb_multi_edge_detect.sv
// tb/tb_multi_edge_detect.sv - scoreboard bench for multi_edge_detect (default and filtered/narrow-counter builds)
module tb_multi_edge_detect;
  import edge_detect_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // Instance A: default parameters
  logic [3:0]  in_a;
  logic [1:0]  mode_a;
  logic        en_a, clr_a;
  logic [3:0]  out_a, level_a;
  logic        any_a;
  logic [63:0] count_a;
  // Instance B: FILT_LEN=3, CNT_W=4
  logic [3:0]  in_b;
  logic [1:0]  mode_b;
  logic        en_b, clr_b;
  logic [3:0]  out_b, level_b;
  logic        any_b;
  logic [15:0] count_b;

  multi_edge_detect u_dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .mode(mode_a), .en(en_a), .clr(clr_a),
    .out(out_a), .level(level_a), .any_edge(any_a), .count(count_a)
  );

  multi_edge_detect #(.N_CH(4), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .mode(mode_b), .en(en_b), .clr(clr_b),
    .out(out_b), .level(level_b), .any_edge(any_b), .count(count_b)
  );

  typedef struct {
    int         cyc;
    logic [3:0] bits;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Toggle instance A channel 0 n times every 2 cycles; push the pulses mode m should give.
  task automatic toggle_a0(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) begin
      in_a[0] = ~in_a[0];
      if ((in_a[0] && (m == EDGE_RISE || m == EDGE_BOTH)) ||
          (!in_a[0] && (m == EDGE_FALL || m == EDGE_BOTH)))
        q_a.push_back('{cyc + 3, 4'b0001});
      step(2);
    end
  endtask

  // Monitor A: pops an expectation whenever a pulse appears.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n) begin
      while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
        e = q_a.pop_front();
        total++;
        bad++;
        $display("FAIL a_missed_pulse: got none expected out=%b at cycle %0d", e.bits, e.cyc);
      end
      chk("a_any_edge", 64'(any_a), 64'(|out_a));
      if (out_a != 4'b0) begin
        if (q_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_unexpected_pulse: got out=%b expected none at cycle %0d", out_a, cyc);
        end else begin
          e = q_a.pop_front();
          chk("a_pulse_cycle", 64'(cyc), 64'(e.cyc));
          chk("a_pulse_bits", 64'(out_a), 64'(e.bits));
        end
      end
    end
  end

  // Monitor B: same scheme for the filtered instance.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n) begin
      while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
        e = q_b.pop_front();
        total++;
        bad++;
        $display("FAIL b_missed_pulse: got none expected out=%b at cycle %0d", e.bits, e.cyc);
      end
      chk("b_any_edge", 64'(any_b), 64'(|out_b));
      if (out_b != 4'b0) begin
        if (q_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected_pulse: got out=%b expected none at cycle %0d", out_b, cyc);
        end else begin
          e = q_b.pop_front();
          chk("b_pulse_cycle", 64'(cyc), 64'(e.cyc));
          chk("b_pulse_bits", 64'(out_b), 64'(e.bits));
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    in_a   = 4'b1000;   // channel 3 held high through reset
    mode_a = EDGE_RISE;
    en_a   = 1'b0;
    clr_a  = 1'b0;
    in_b   = 4'b0000;
    mode_b = EDGE_RISE;
    en_b   = 1'b1;
    clr_b  = 1'b0;

    #1;
    chk("rst_out_a", 64'(out_a), 64'h0);
    chk("rst_level_a", 64'(level_a), 64'h0);
    chk("rst_any_a", 64'(any_a), 64'h0);
    chk("rst_count_a", count_a, 64'h0);
    chk("rst_count_b", 64'(count_b), 64'h0);
    step(3);
    chk("rst_level_a_clocked", 64'(level_a), 64'h0);

    // Input high at release, en low: level follows, no pulse, no count.
    rst_n = 1'b1;
    step(5);
    chk("hold_level3", 64'(level_a[3]), 64'h1);
    en_a = 1'b1;
    step(4);
    chk("hold_count3", 64'(count_a[63:48]), 64'h0);

    // Rise mode: 50 toggles -> 25 pulses.
    toggle_a0(50, EDGE_RISE);
    step(4);
    chk("rise_count0", 64'(count_a[15:0]), 64'd25);
    chk("rise_count12", 64'(count_a[47:16]), 64'h0);

    // Clear, then both-edge mode: 50 pulses.
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    chk("clr_count0", 64'(count_a[15:0]), 64'h0);
    mode_a = EDGE_BOTH;
    toggle_a0(50, EDGE_BOTH);
    step(4);
    chk("both_count0", 64'(count_a[15:0]), 64'd50);

    // Fall mode: 10 toggles -> 5 pulses.
    clr_a  = 1'b1;
    step(1);
    clr_a  = 1'b0;
    mode_a = EDGE_FALL;
    toggle_a0(10, EDGE_FALL);
    step(4);
    chk("fall_count0", 64'(count_a[15:0]), 64'd5);

    // None mode: no pulses, level still tracks.
    mode_a = EDGE_NONE;
    toggle_a0(10, EDGE_NONE);
    in_a[0] = 1'b1;
    step(4);
    chk("none_level_hi", 64'(level_a[0]), 64'h1);
    in_a[0] = 1'b0;
    step(4);
    chk("none_level_lo", 64'(level_a[0]), 64'h0);
    chk("none_count0", 64'(count_a[15:0]), 64'd5);

    // Back-to-back edges give pulses on consecutive cycles.
    mode_a  = EDGE_BOTH;
    in_a[0] = 1'b1;
    q_a.push_back('{cyc + 3, 4'b0001});
    step(1);
    in_a[0] = 1'b0;
    q_a.push_back('{cyc + 3, 4'b0001});
    step(6);
    chk("b2b_count0", 64'(count_a[15:0]), 64'd7);

    // en low: level tracks, nothing counts, raising en does not replay.
    mode_a  = EDGE_RISE;
    en_a    = 1'b0;
    in_a[0] = 1'b1;
    step(4);
    chk("en0_level", 64'(level_a[0]), 64'h1);
    en_a = 1'b1;
    step(4);
    in_a[0] = 1'b0;
    step(4);
    chk("en0_count0", 64'(count_a[15:0]), 64'd7);

    // Mode sampled at the detecting edge: switch to fall before the rise is detected.
    in_a[0] = 1'b1;
    step(2);
    mode_a = EDGE_FALL;
    step(4);
    in_a[0] = 1'b0;
    q_a.push_back('{cyc + 3, 4'b0001});
    step(5);
    chk("modesw_count0", 64'(count_a[15:0]), 64'd8);

    // Simultaneous edges on channels 0 and 2.
    mode_a = EDGE_RISE;
    in_a[0] = 1'b1;
    in_a[2] = 1'b1;
    q_a.push_back('{cyc + 3, 4'b0101});
    step(5);
    chk("sim_count0", 64'(count_a[15:0]), 64'd9);
    chk("sim_count2", 64'(count_a[47:32]), 64'd1);
    in_a[0] = 1'b0;
    in_a[2] = 1'b0;
    step(4);

    // Filtered instance: 1-, 2-, 3-cycle glitches are rejected.
    for (int len = 1; len <= 3; len++) begin
      in_b[1] = 1'b1;
      step(len);
      in_b[1] = 1'b0;
      step(8);
      chk($sformatf("glitch%0d_level", len), 64'(level_b), 64'h0);
      chk($sformatf("glitch%0d_count1", len), 64'(count_b[7:4]), 64'h0);
    end
    // A 4-cycle high passes, level rising after edge 5.
    in_b[1] = 1'b1;
    q_b.push_back('{cyc + 6, 4'b0010});
    step(4);
    in_b[1] = 1'b0;
    step(1);
    chk("filt_level_early", 64'(level_b[1]), 64'h0);
    step(1);
    chk("filt_level_rise", 64'(level_b[1]), 64'h1);
    step(12);
    chk("filt_level_fall", 64'(level_b[1]), 64'h0);
    chk("filt_count1", 64'(count_b[7:4]), 64'd1);

    // clr coincident with an edge: count cleared, pulse still emitted.
    in_b[0] = 1'b1;
    q_b.push_back('{cyc + 6, 4'b0001});
    step(5);
    clr_b = 1'b1;
    step(1);
    clr_b = 1'b0;
    chk("clr_edge_count0", 64'(count_b[3:0]), 64'h0);
    in_b[0] = 1'b0;
    step(6);
    chk("clr_edge_count0_hold", 64'(count_b[3:0]), 64'h0);

    // 20 rises on a 4-bit counter saturate at 15.
    for (int i = 0; i < 20; i++) begin
      in_b[0] = 1'b1;
      q_b.push_back('{cyc + 6, 4'b0001});
      step(5);
      in_b[0] = 1'b0;
      step(5);
    end
    step(4);
    chk("sat_count0", 64'(count_b[3:0]), 64'd15);

    chk("queue_a_empty", 64'(q_a.size()), 64'h0);
    chk("queue_b_empty", 64'(q_b.size()), 64'h0);

    // Asynchronous reset between clock edges clears everything at once.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_a", 64'(out_a), 64'h0);
    chk("async_level_a", 64'(level_a), 64'h0);
    chk("async_any_a", 64'(any_a), 64'h0);
    chk("async_count_a", count_a, 64'h0);
    chk("async_count_b", 64'(count_b), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_edge_detect.md
Name: multi_edge_detect

Overview:
- Parametrised multi-channel successor to the single-bit edge detector, for the delay-line front end.
- Per channel: resynchronises an asynchronous input, then rejects glitches with a persistence filter.
- Detects rising, falling or both edges, selected at run time; emits a one-cycle pulse per qualifying edge.
- Keeps a saturating per-channel edge counter for rate and debug readout.

Parameters:
- N_CH, 4: number of independent input channels.
- SYNC_STAGES, 2: synchroniser flops per channel; minimum 2.
- FILT_LEN, 0: extra consecutive cycles a new level must persist before it is accepted; 0 bypasses the filter.
- CNT_W, 16: width of each per-channel edge counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  N_CH  asynchronous channel inputs.
- mode  in  2  edge select, all channels: 00 rise, 01 fall, 10 both, 11 none.
- en  in  1  enables pulse output and counting.
- clr  in  1  synchronous clear of all edge counters.
- out  out  N_CH  one-cycle edge pulse per channel, registered.
- level  out  N_CH  filtered, synchronised level per channel.
- any_edge  out  1  OR of out.
- count  out  N_CH*CNT_W  edge counters; channel k occupies bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset (async, rst_n=0): synchroniser flops, level, filter counters, out, any_edge and count all go to 0 immediately, regardless of clk.
- Synchroniser: in[k] passes through SYNC_STAGES flops. Call the last stage s[k].
- Filter counter: width clog2(FILT_LEN+1).
  - While s[k]==level[k], the counter is held at 0.
  - While s[k]!=level[k], it increments each cycle.
  - On the edge where s[k]!=level[k] and counter==FILT_LEN: level[k] takes s[k] and the counter returns to 0.
  - Any mismatch run shorter than FILT_LEN+1 cycles is discarded and never reaches level.
- Edge qualify, computed at the same edge where level[k] changes:
  - rise = level 0->1; fall = level 1->0.
  - qualify = (mode==00 & rise) | (mode==01 & fall) | (mode==10 & (rise|fall)); mode 11 never qualifies.
- out[k] is set for exactly one cycle after that edge if qualify & en; otherwise it is 0.
- Latency: in changes before capture edge 0 -> level and out change after edge SYNC_STAGES+FILT_LEN. Defaults give edge 2.
- Consecutive levels: a level held >= FILT_LEN+1 cycles produces its own pulse, so back-to-back edges give pulses on consecutive cycles.
- mode and en are sampled at the detecting edge only; there is no pipelining of either. Changing them affects only edges detected afterwards.
- en=0: synchroniser, filter and level keep tracking; out stays 0 and counters hold. Asserting en does not replay edges that occurred while it was low.
- After reset, level=0. An input held high at release therefore produces a rise after SYNC_STAGES+FILT_LEN cycles. Software holds en=0 until the inputs have settled.
- Counter update: count[k] increments on each cycle where out[k] is set next.
  - It saturates at 2^CNT_W-1 and never wraps.
  - clr=1 forces all counters to 0 on the next edge; clr wins over a simultaneous increment.
  - out is unaffected by clr.
- any_edge is the combinational OR of the out registers and is 0 in reset.
- Channels are fully independent. Simultaneous edges on several channels each pulse and count.

Decomposition:
- Package edge_detect_pkg holds:
  - mode constants EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_NONE=2'b11;
  - a clog2 helper function.
- Sub-module edge_chan implements one channel (synchroniser, filter, detect, saturating counter). It is instanced N_CH times by a generate loop.
- The top level holds only the count packing and the any_edge OR.

Test Plan:
- Defaults, mode=00, en=1; toggle in[0] every 2 cycles for 50 toggles -> 25 one-cycle out[0] pulses, each 2 edges after the rise, and count[0]=25 at the end. Other channels stay 0.
- mode=10, same stimulus -> 50 pulses, count=50. Then mode=01 -> pulses only on falls. mode=11 -> no pulses while level still tracks.
- FILT_LEN=3; apply 1-, 2- and 3-cycle high glitches on in[1] -> level and out unchanged. A 4-cycle high -> level rises after edge 2+3=5 with a single out pulse.
- CNT_W=4; 20 rising edges -> count saturates at 15 and does not wrap. Assert clr on the same cycle as an edge -> count=0 and the pulse is still emitted.
- Hold in[3]=1 through reset with en=0, release, wait 5 cycles, set en=1 -> no pulse and count=0. Drop rst_n mid-stream between clocks -> all outputs read 0 immediately.
- Pulse in[0] and in[2] simultaneously -> both out bits and any_edge high in the same cycle, both counters +1.
